// File: rtl/branch_resolve_stage_pkg.sv
// Shared RISC-V control-flow constants, D/E payload and immediate helpers.
// Also used by the fetch stage.
package branch_resolve_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;

  localparam logic [XLEN-1:0]  ZERO_W     = '0;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_R010 = 3'b010;
  localparam logic [F3_W-1:0] F3_R011 = 3'b011;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } de_reg_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_resolve_stage_branch_cmp.sv
// Conditional-branch comparator: decodes funct3 into taken/illegal.
module branch_cmp
  import branch_resolve_stage_pkg::*;
(
  input  logic [F3_W-1:0] i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken_c,
  output logic            o_illegal_c
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_taken_c   = 1'b0;
    o_illegal_c = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken_c = w_eq;
      F3_BNE:  o_taken_c = ~w_eq;
      F3_BLT:  o_taken_c = w_lt;
      F3_BGE:  o_taken_c = ~w_lt;
      F3_BLTU: o_taken_c = w_ltu;
      F3_BGEU: o_taken_c = ~w_ltu;
      F3_R010, F3_R011: o_illegal_c = 1'b1;
      default: o_taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// Decode-to-execute register plus JAL/JALR/branch resolution and fetch redirect.
// A redirect squashes the two younger instructions already in flight.
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   i_instr_d,
  input  logic [XLEN-1:0]   i_pc_d,
  output logic [REG_AW-1:0] o_rs1_addr,
  output logic [REG_AW-1:0] o_rs2_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  output logic              o_pc_r,
  output logic [XLEN-1:0]   o_pc_ex,
  output logic [XLEN-1:0]   o_pc_disp,
  output logic              o_valid_e,
  output logic [XLEN-1:0]   o_instr_e,
  output logic [XLEN-1:0]   o_pc_e,
  output logic              o_link_we,
  output logic [REG_AW-1:0] o_link_rd,
  output logic [XLEN-1:0]   o_link_data,
  output logic              o_illegal_e,
  output logic [XLEN-1:0]   o_redirect_cnt
);

  de_reg_t         r_de;
  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_kill;
  logic [XLEN-1:0] r_redirect_cnt;

  logic [OPC_W-1:0] w_opcode;
  logic             w_is_jal;
  logic             w_is_jalr;
  logic             w_is_branch;
  logic             w_taken;
  logic             w_illegal;
  logic [XLEN-1:0]  w_jalr_sum;
  logic             w_pc_r;
  logic [XLEN-1:0]  w_pc_ex;
  logic [XLEN-1:0]  w_pc_disp;

  assign o_rs1_addr = i_instr_d[19:15];
  assign o_rs2_addr = i_instr_d[24:20];

  assign w_opcode    = r_de.instr[6:0];
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_jalr   = (w_opcode == OPC_JALR);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_jalr_sum  = r_de.rs1 + imm_i(r_de.instr);

  branch_cmp u_branch_cmp (
    .i_funct3    (r_de.instr[14:12]),
    .i_rs1       (r_de.rs1),
    .i_rs2       (r_de.rs2),
    .o_taken_c   (w_taken),
    .o_illegal_c (w_illegal)
  );

  // Redirect triple, driven only by a live execute slot
  always_comb begin
    w_pc_r    = 1'b0;
    w_pc_ex   = ZERO_W;
    w_pc_disp = ZERO_W;
    if (r_de.valid) begin
      if (w_is_jal) begin
        w_pc_r    = 1'b1;
        w_pc_ex   = r_de.pc;
        w_pc_disp = imm_j(r_de.instr);
      end else if (w_is_jalr) begin
        w_pc_r    = 1'b1;
        w_pc_ex   = {w_jalr_sum[XLEN-1:1], 1'b0};
      end else if (w_is_branch && w_taken) begin
        w_pc_r    = 1'b1;
        w_pc_ex   = r_de.pc;
        w_pc_disp = imm_b(r_de.instr);
      end
    end
  end

  // Squash FSM: the redirect edge kills P+4, the following edge kills P+8
  always_comb begin
    w_state_nxt = r_state;
    w_kill      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_pc_r) begin
          w_state_nxt = ST_SQUASH;
          w_kill      = 1'b1;
        end
      end
      ST_SQUASH: begin
        w_state_nxt = ST_RUN;
        w_kill      = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de <= '0;
    end else begin
      r_de.valid <= (i_instr_d != ZERO_W) & ~w_kill;
      r_de.instr <= i_instr_d;
      r_de.pc    <= i_pc_d;
      r_de.rs1   <= i_rs1_data;
      r_de.rs2   <= i_rs2_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect_cnt <= ZERO_W;
    end else if (w_pc_r) begin
      r_redirect_cnt <= r_redirect_cnt + XLEN'(1);
    end
  end

  assign o_pc_r         = w_pc_r;
  assign o_pc_ex        = w_pc_ex;
  assign o_pc_disp      = w_pc_disp;
  assign o_valid_e      = r_de.valid;
  assign o_instr_e      = r_de.instr;
  assign o_pc_e         = r_de.pc;
  assign o_link_we      = r_de.valid & (w_is_jal | w_is_jalr);
  assign o_link_rd      = r_de.instr[11:7];
  assign o_link_data    = r_de.pc + XLEN'(4);
  assign o_illegal_e    = r_de.valid & w_is_branch & w_illegal;
  assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed scoreboard bench for branch_resolve_stage: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares.
module tb_branch_resolve_stage;

  logic        clk;
  logic        rst;
  logic [31:0] i_instr_d, i_pc_d, i_rs1_data, i_rs2_data;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_link_rd;
  logic        o_pc_r, o_valid_e, o_link_we, o_illegal_e;
  logic [31:0] o_pc_ex, o_pc_disp, o_instr_e, o_pc_e, o_link_data, o_redirect_cnt;

  branch_resolve_stage dut (
    .clk            (clk),
    .rst            (rst),
    .i_instr_d      (i_instr_d),
    .i_pc_d         (i_pc_d),
    .o_rs1_addr     (o_rs1_addr),
    .o_rs2_addr     (o_rs2_addr),
    .i_rs1_data     (i_rs1_data),
    .i_rs2_data     (i_rs2_data),
    .o_pc_r         (o_pc_r),
    .o_pc_ex        (o_pc_ex),
    .o_pc_disp      (o_pc_disp),
    .o_valid_e      (o_valid_e),
    .o_instr_e      (o_instr_e),
    .o_pc_e         (o_pc_e),
    .o_link_we      (o_link_we),
    .o_link_rd      (o_link_rd),
    .o_link_data    (o_link_data),
    .o_illegal_e    (o_illegal_e),
    .o_redirect_cnt (o_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pce;
    logic        pcr;
    logic [31:0] pcex;
    logic [31:0] disp;
    logic        lwe;
    logic [4:0]  lrd;
    logic        ill;
    logic [31:0] cnt;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                        input logic [4:0] r1, input logic [4:0] r2);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [4:0] r1,
                                           input logic [4:0] rd);
    return {imm, r1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic exp_t ex(input logic v, input logic [31:0] pce, input logic pcr,
                              input logic [31:0] pcex, input logic [31:0] disp,
                              input logic lwe, input logic [4:0] lrd, input logic ill,
                              input logic [31:0] cnt);
    exp_t e;
    e.v = v; e.pce = pce; e.pcr = pcr; e.pcex = pcex; e.disp = disp;
    e.lwe = lwe; e.lrd = lrd; e.ill = ill; e.cnt = cnt;
    e.rs1a = 5'd0; e.rs2a = 5'd0;
    return e;
  endfunction

  function automatic exp_t bub(input logic [31:0] cnt);
    return ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, cnt);
  endfunction

  function automatic exp_t nop_e(input logic [31:0] pce, input logic [31:0] cnt);
    return ex(1'b1, pce, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, cnt);
  endfunction

  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e_in);
    exp_t e;
    e = e_in;
    rst        = r;
    i_instr_d  = ins;
    i_pc_d     = pc;
    i_rs1_data = a;
    i_rs2_data = b;
    e.rs1a     = ins[19:15];
    e.rs2a     = ins[24:20];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL cyc%0d %s: got 0x%08h expected 0x%08h", cyc, name, act, exp_v);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid_e",      32'(o_valid_e),   32'(e.v));
      chk("pc_r",         32'(o_pc_r),      32'(e.pcr));
      chk("pc_ex",        o_pc_ex,          e.pcex);
      chk("pc_disp",      o_pc_disp,        e.disp);
      chk("link_we",      32'(o_link_we),   32'(e.lwe));
      chk("illegal_e",    32'(o_illegal_e), 32'(e.ill));
      chk("redirect_cnt", o_redirect_cnt,   e.cnt);
      chk("rs1_addr",     32'(o_rs1_addr),  32'(e.rs1a));
      chk("rs2_addr",     32'(o_rs2_addr),  32'(e.rs2a));
      if (e.v) chk("pc_e", o_pc_e, e.pce);
      if (e.lwe) begin
        chk("link_rd",   32'(o_link_rd), 32'(e.lrd));
        chk("link_data", o_link_data,    e.pce + 32'd4);
      end
      cyc++;
    end
  end

  initial begin
    rst = 1'b0; i_instr_d = '0; i_pc_d = '0; i_rs1_data = '0; i_rs2_data = '0;
    @(posedge clk);
    #1;
    // Reset held with random fetch traffic
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, $urandom, $urandom, $urandom, bub(0));
    step(1'b1, NOP, 32'h0FC, 0, 0, bub(0));
    // BEQ +16 taken, then two squashed slots
    step(1'b1, enc_b(13'd16, 3'b000, 5'd2, 5'd3), 32'h100, 5, 5, nop_e(32'h0FC, 0));
    step(1'b1, NOP, 32'h104, 0, 0, ex(1, 32'h100, 1, 32'h100, 32'h10, 0, 0, 0, 0));
    step(1'b1, NOP, 32'h108, 0, 0, bub(1));
    step(1'b1, NOP, 32'h110, 0, 0, bub(1));
    // BLT -8 signed taken
    step(1'b1, enc_b(13'h1FF8, 3'b100, 5'd2, 5'd3), 32'h114, 32'hFFFF_FFFF, 1,
         nop_e(32'h110, 1));
    step(1'b1, NOP, 32'h118, 0, 0, ex(1, 32'h114, 1, 32'h114, 32'hFFFF_FFF8, 0, 0, 0, 1));
    step(1'b1, NOP, 32'h11C, 0, 0, bub(2));
    // BLTU same operands, not taken; JALR behind it
    step(1'b1, enc_b(13'h1FF8, 3'b110, 5'd2, 5'd3), 32'h10C, 32'hFFFF_FFFF, 1, bub(2));
    step(1'b1, enc_jalr(12'd4, 5'd2, 5'd1), 32'h110, 32'h2003, 0,
         ex(1, 32'h10C, 0, 0, 0, 0, 0, 0, 2));
    step(1'b1, NOP, 32'h114, 0, 0, ex(1, 32'h110, 1, 32'h2006, 0, 1, 5'd1, 0, 2));
    step(1'b1, NOP, 32'h118, 0, 0, bub(3));
    // JAL followed by a would-be-taken BNE
    step(1'b1, enc_j(21'h40, 5'd1), 32'h200, 0, 0, bub(3));
    step(1'b1, enc_b(13'd8, 3'b001, 5'd2, 5'd3), 32'h204, 1, 2,
         ex(1, 32'h200, 1, 32'h200, 32'h40, 1, 5'd1, 0, 3));
    step(1'b1, NOP, 32'h208, 0, 0, bub(4));
    // Reserved funct3 and an all-zero bubble
    step(1'b1, enc_b(13'd8, 3'b010, 5'd2, 5'd3), 32'h240, 3, 3, bub(4));
    step(1'b1, 32'h0, 32'h244, 0, 0, ex(1, 32'h240, 0, 0, 0, 0, 0, 1, 4));
    step(1'b1, NOP, 32'h248, 0, 0, bub(4));
    // Redirect, then reset lands during the squash window
    step(1'b1, enc_b(13'd16, 3'b000, 5'd2, 5'd3), 32'h24C, 7, 7, nop_e(32'h248, 4));
    step(1'b1, NOP, 32'h250, 0, 0, ex(1, 32'h24C, 1, 32'h24C, 32'h10, 0, 0, 0, 4));
    step(1'b0, NOP, 32'h300, 0, 0, bub(0));
    step(1'b1, NOP, 32'h304, 0, 0, bub(0));
    step(1'b1, NOP, 32'h308, 0, 0, nop_e(32'h304, 0));
    step(1'b1, NOP, 32'h30C, 0, 0, nop_e(32'h308, 0));
    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Decode/execute-side control-flow resolver for the RISC-V pipeline. Consumes the instruction and PC delivered by the fetch stage and latches them with register-file operands into a decode-to-execute register. Resolves JAL, JALR and conditional branches in execute and drives the fetch redirect triple: fetch next PC = pc_r ? pc_ex + pc_disp : PC + 4. Squashes the two wrong-path instructions already in flight after a redirect.

## Interface
- No parameters; widths come from the shared constants (instruction/PC width 32).
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- instr_d  in  32  instruction from fetch (fetch InstrD)
- pc_d  in  32  PC of instr_d (fetch PC_DE)
- rs1_addr, rs2_addr  out  5  instr_d[19:15], instr_d[24:20], combinational
- rs1_data, rs2_data  in  32  register-file read data for rs1_addr/rs2_addr, same cycle
- pc_r  out  1  redirect request to fetch
- pc_ex  out  32  redirect base
- pc_disp  out  32  redirect displacement
- valid_e  out  1  execute slot holds a live instruction
- instr_e, pc_e  out  32  execute-slot instruction and PC
- link_we  out  1  JAL/JALR writeback strobe
- link_rd  out  5  link destination, instr_e[11:7]
- link_data  out  32  pc_e + 4
- illegal_e  out  1  BRANCH opcode with funct3 010 or 011 in a live slot
- redirect_cnt  out  32  count of redirects issued, wrapping

## Operation
- Decode: opcode 1101111 JAL, 1100111 JALR, 1100011 BRANCH; anything else is pass-through and never redirects. instr_d == 0 is a bubble: captured with valid 0.
- D/E register captures instr_d, pc_d, rs1_data, rs2_data, valid on every clk rising edge; valid is forced to 0 while squashing (see FSM).
- Immediates, sign-extended to 32: immI = instr[31:20]; immB = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; immJ = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Branch compare on latched operands: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 not taken, illegal_e = 1.
- Redirect, combinational from D/E register, only when valid_e:
  - JAL: pc_r = 1, pc_ex = pc_e, pc_disp = immJ.
  - JALR: pc_r = 1, pc_ex = (rs1 + immI) & ~1, pc_disp = 0.
  - Taken branch: pc_r = 1, pc_ex = pc_e, pc_disp = immB.
  - Otherwise pc_r = 0, pc_ex = 0, pc_disp = 0.
- All additions are 32-bit modulo; no overflow detection.
- link_we = valid_e & (JAL | JALR), including when rd = 0. Consumers ignore rd = 0.
- FSM, 2 states:
  - RUN: on an edge with pc_r = 1, capture a bubble and go to SQUASH. Otherwise capture normally.
  - SQUASH: capture a bubble and return to RUN unconditionally.
  - A redirect cannot occur in SQUASH, because valid_e = 0.
- redirect_cnt increments on every edge where pc_r = 1.

## Timing
- Cycle n: branch at P in execute; P+4 in decode; fetch PC = P+8. pc_r asserts in cycle n.
- Edge ending cycle n: fetch loads the target, and P+4 is killed entering E. Edge ending n+1: P+8 is killed. Target instruction is valid in E at cycle n+3.
- Redirect penalty: exactly 2 bubbles. Resolution latency: 1 cycle from decode.
- Reset (rst low, asynchronous): D/E register cleared (valid_e 0, instr_e 0, pc_e 0), FSM to RUN, redirect_cnt 0.
- Outputs during reset: pc_r 0, pc_ex 0, pc_disp 0, link_we 0, illegal_e 0.
- Reset released mid-squash: resumes in RUN with no residual kill.
- Back-to-back branches (P, P+4 both taken): only P redirects; P+4 is squashed.

## Structure
- Shared constants package/header: opcode values, funct3 codes, instruction width, zero constant. The fetch stage uses the same header.
- One sub-module, branch_cmp: combinational funct3 comparator returning taken and illegal.
- Remainder is flat: immediate generation, D/E register, FSM, counter.

## Test plan
- Reset: hold rst low for 3 cycles with random instr_d -> valid_e 0, pc_r 0, redirect_cnt 0. Release -> normal capture on the next edge.
- BEQ, pc_d 0x100, immB +16, rs1 = rs2 = 5 -> pc_r 1, pc_ex 0x100, pc_disp 0x10. Next two captures are bubbles; redirect_cnt 1.
- BLT -8 with rs1 = 0xFFFFFFFF, rs2 = 1 -> taken. BLTU with the same operands -> not taken, pc_r 0.
- JALR rd = 1, rs1 = 0x2003, immI = 4 -> pc_ex 0x2006, pc_disp 0, link_we 1, link_data pc_e + 4.
- JAL at 0x200 followed by a taken BNE at 0x204 -> single redirect; the BNE is never valid in E; redirect_cnt 1.
- BRANCH with funct3 010 -> illegal_e 1, pc_r 0. instr_d 0 -> valid_e 0.
